// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit seven-segment scanner.
// Optional feature macro used by the scanner: LEADING_ZERO_BLANK_EN.
package seg_scan_mux_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

    typedef logic [1:0] slot_t;

    // Per-digit leading-zero flags: bit k set when digit k (k > 0) and every
    // higher digit are zero. Digit 0 is always kept so a zero value shows "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
        input logic [NUM_DIGITS*NIBBLE_W-1:0] v
    );
        logic [NUM_DIGITS-1:0] mask;
        mask = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            mask[k] = ((v >> (NIBBLE_W * k)) == '0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_mux_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the last count.
module scan_tick_gen #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // With REFRESH_DIV = 1 the counter sits at 0 and tick stays high every cycle.
    assign tick = (cnt == CNT_MAX);

    // Free-running counter with wrap on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed display scanner with registered anode/digit/dp.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [NIBBLE_W-1:0]           digit,
    output logic                          dp
);

    logic                          tick;
    slot_t                         idx;
    logic [NUM_DIGITS*NIBBLE_W-1:0] disp_reg;
    logic [NUM_DIGITS-1:0]         dp_reg;
    logic [NUM_DIGITS-1:0]         zero_mask;
    logic                          slot_lit;
    logic [NUM_DIGITS-1:0]         an_next;
    logic [NIBBLE_W-1:0]           digit_next;
    logic                          dp_next;

    scan_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Slot index advances once per prescaler wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 1'b1;
        end
    end

    // Capture new display contents whenever load is sampled high.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_reg <= '0;
            dp_reg   <= '0;
        end else if (load) begin
            disp_reg <= value;
            dp_reg   <= dp_in;
        end
    end

    // Decode the current slot into the next anode, nibble and dp values.
    always_comb begin
        zero_mask  = '0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_mask  = lead_zero_mask(disp_reg);
`endif
        slot_lit   = !blank && !zero_mask[idx];
        digit_next = disp_reg[idx*NIBBLE_W +: NIBBLE_W];
        an_next    = AN_ALL_OFF;
        dp_next    = 1'b1;
        if (slot_lit) begin
            an_next = ~(4'b0001 << idx);
            dp_next = ~dp_reg[idx];
        end
    end

    // Output register: one cycle behind idx/disp_reg/dp_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            an    <= AN_ALL_OFF;
            digit <= '0;
            dp    <= 1'b1;
        end else begin
            an    <= an_next;
            digit <= digit_next;
            dp    <= dp_next;
        end
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal range >= 1).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load  input  1  capture strobe for value and dp_in.
REQ-005 SHALL have port value  input  16  four hex digits; nibble k feeds digit k, with digit 0 the rightmost.
REQ-006 SHALL have port dp_in  input  4  decimal-point request per digit, active-high.
REQ-007 SHALL have port blank  input  1  level; high turns the whole display off.
REQ-008 SHALL have port an  output  4  digit enables, active-low, at most one low.
REQ-009 SHALL have port digit  output  4  hex nibble for the downstream segment decoder.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-011 SHALL keep prescaler cnt counting 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle cnt = REFRESH_DIV-1.
REQ-012 SHALL advance 2-bit slot index idx by 1 on each tick, wrapping 3 -> 0 (sequence 0,1,2,3,0,...).
REQ-013 SHALL capture value into disp_reg and dp_in into dp_reg at the edge that samples load = 1; while load = 0, both registers hold.
REQ-014 SHALL register an, digit and dp, each computed from the current idx, disp_reg, dp_reg, blank and digit-blank state; outputs therefore lag those registers by exactly 1 cycle.
REQ-015 SHALL drive an = ~(4'b0001 << idx), digit = disp_reg[4*idx+3:4*idx] and dp = ~dp_reg[idx] when the slot is not blanked.
REQ-016 SHALL, for a blanked slot (blank = 1, or slot blanked per REQ-022), drive an = 4'b1111, dp = 1 and digit = disp_reg nibble unchanged.
REQ-017 SHALL keep the prescaler and idx running while blank = 1; deasserting blank resumes display in the current slot with no re-sync.
REQ-018 SHALL let load and tick in the same cycle both take effect; the new slot shows the new value.
REQ-019 SHALL accept load in every cycle with no busy state; back-to-back loads keep the last one.
REQ-020 SHALL, when REFRESH_DIV = 1, assert tick every cycle and advance idx every cycle.

Reset
REQ-021 SHALL on rst = 1 set cnt = 0, idx = 0, disp_reg = 16'h0000, dp_reg = 4'b0000, an = 4'b1111, digit = 4'h0 and dp = 1; rst overrides load, tick and blank, including mid-scan; the first edge after rst drops drives an = 4'b1110.

Configuration
REQ-022 SHALL, with LEADING_ZERO_BLANK_EN defined, blank every digit k > 0 whose nibble and all higher nibbles of disp_reg are zero; digit 0 is never blanked by this rule (0x0000 shows one "0"; 0x00A0 shows digits 1 and 0). Decimal points do not affect this rule.
REQ-023 SHALL, without LEADING_ZERO_BLANK_EN, display all four digits unconditionally; there is no other behavioural difference.

Structure
REQ-024 SHALL place in the shared display package: the digit-count constant (4), the nibble width (4), and the all-off anode constant 4'b1111.
REQ-025 SHALL implement the prescaler as sub-module scan_tick_gen (ports clk, rst; output tick; parameter REFRESH_DIV); all other logic stays in seg_scan_mux.

Verification (REFRESH_DIV = 4 unless stated)
REQ-026 SHALL cover: reset, then value=16'h1234, load 1 cycle -> an cycles 1110,1101,1011,0111 every 4 cycles, with digit 4,3,2,1 in step; dp = 1 throughout.
REQ-027 SHALL cover: dp_in=4'b0100 loaded -> dp = 0 only while an = 4'b1011.
REQ-028 SHALL cover: blank high for 10 cycles mid-scan -> an = 4'b1111 one cycle after blank rises; after blank drops, idx continues with no restart.
REQ-029 SHALL cover: load asserted in the tick cycle with value=16'hABCD -> the next slot shows the nibble of 16'hABCD for its index.
REQ-030 SHALL cover, with LEADING_ZERO_BLANK_EN: value=16'h0050 -> an = 4'b1111 in slots 3 and 2; slots 1 and 0 show 5 and 0. With value=16'h0000, only slot 0 is lit, showing 0.
REQ-031 SHALL cover: rst asserted in slot 2 mid-count -> next edge an = 4'b1111 and digit = 0; after release, scan restarts at slot 0, and REFRESH_DIV = 1 advances idx every cycle.
